// File: rtl/usb_line_ctrl.sv
// -----------------------------------------------------------------------------
// usb_line_ctrl
//
// Full-speed bus line-condition controller on the UTMI receive side.
// Watches the registered line state and the rx/tx activity flags to detect
// bus reset, suspend and host resume. Sequences device remote wakeup by
// asking the transmitter to drive K. Drives SuspendM back to the macrocell
// and reports bus events to the SIE.
//
// All cycle counts are in clk cycles (48 MHz, 4x the FS bit rate).
//
// Ports:
//   clk               in   clock
//   rst               in   asynchronous, active-high reset
//   line_state        in   registered line state from the UTM receiver
//   rx_active         in   receive FSM active
//   tx_active         in   transmitter active
//   remote_wakeup_en  in   host has enabled remote wakeup (level)
//   wakeup_req        in   wakeup request, level held by the requester
//   suspend_m         out  UTMI SuspendM, 0 = macrocell suspended
//   usb_reset         out  high while in BUS_RESET
//   usb_suspend       out  high while in SUSPENDED or WAKEUP
//   resume_done       out  one-cycle pulse on RESUMING -> ACTIVE
//   drive_k           out  request to the transmitter to force K on the bus
//   ctrl_state        out  current FSM state encoding (debug)
// -----------------------------------------------------------------------------

package usb_line_pkg;

    // UTMI LineState encoding: {DM, DP} as seen by a full-speed receiver.
    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_J   = 2'b01,
        LS_K   = 2'b10,
        LS_SE1 = 2'b11
    } utmi_line_state_t;

endpackage

module usb_line_ctrl
    import usb_line_pkg::*;
#(
    parameter int RESET_DETECT_CYC  = 480,
    parameter int SUSPEND_CYC       = 144000,
    parameter int RESUME_DETECT_CYC = 48,
    parameter int WAKEUP_IDLE_CYC   = 240000,
    parameter int WAKEUP_DRIVE_CYC  = 96000
) (
    input  logic             clk,
    input  logic             rst,
    input  utmi_line_state_t line_state,
    input  logic             rx_active,
    input  logic             tx_active,
    input  logic             remote_wakeup_en,
    input  logic             wakeup_req,
    output logic             suspend_m,
    output logic             usb_reset,
    output logic             usb_suspend,
    output logic             resume_done,
    output logic             drive_k,
    output logic [2:0]       ctrl_state
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(max2(RESET_DETECT_CYC, SUSPEND_CYC),
                                       max2(RESUME_DETECT_CYC, WAKEUP_IDLE_CYC)),
                                  WAKEUP_DRIVE_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    // A run counter holds the number of qualifying samples *before* the
    // current one, so the N-th sample is the one that sees count N-1.
    localparam cnt_t RESET_LAST   = cnt_t'(RESET_DETECT_CYC - 1);
    localparam cnt_t SUSPEND_LAST = cnt_t'(SUSPEND_CYC - 1);
    localparam cnt_t RESUME_LAST  = cnt_t'(RESUME_DETECT_CYC - 1);
    localparam cnt_t DRIVE_LAST   = cnt_t'(WAKEUP_DRIVE_CYC - 1);
    localparam cnt_t WAKE_IDLE    = cnt_t'(WAKEUP_IDLE_CYC);

    localparam logic [2:0] ST_ACTIVE    = 3'd0;
    localparam logic [2:0] ST_BUS_RESET = 3'd1;
    localparam logic [2:0] ST_SUSPENDED = 3'd2;
    localparam logic [2:0] ST_RESUMING  = 3'd3;
    localparam logic [2:0] ST_WAKEUP    = 3'd4;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

    logic [2:0] state_q, state_d;
    cnt_t       se0_cnt_q, se0_cnt_d;
    cnt_t       idle_cnt_q, idle_cnt_d;
    cnt_t       k_cnt_q, k_cnt_d;
    cnt_t       drv_cnt_q, drv_cnt_d;
    cnt_t       susp_cnt_q, susp_cnt_d;
    logic       se0_seen_q, se0_seen_d;

    logic       suspend_m_q, usb_reset_q, usb_suspend_q, resume_done_q, drive_k_q;

    logic       se0_now, j_now, k_now, idle_now;
    logic       reset_hit, suspend_hit, resume_hit, wake_ok, drive_done;

    // ---------------------------------------------------------------------
    // Line condition decode and run counters
    // ---------------------------------------------------------------------
    always_comb begin
        se0_now  = (line_state == LS_SE0);
        j_now    = (line_state == LS_J);
        k_now    = (line_state == LS_K);
        idle_now = j_now && !rx_active && !tx_active;

        se0_cnt_d  = se0_now  ? sat_inc(se0_cnt_q)  : '0;
        idle_cnt_d = idle_now ? sat_inc(idle_cnt_q) : '0;
        // Our own driven K must not look like a host resume.
        k_cnt_d    = (k_now && !drive_k_q) ? sat_inc(k_cnt_q) : '0;
        drv_cnt_d  = (state_q == ST_WAKEUP)    ? sat_inc(drv_cnt_q)  : '0;
        susp_cnt_d = (state_q == ST_SUSPENDED) ? sat_inc(susp_cnt_q) : '0;

        reset_hit   = se0_now  && (se0_cnt_q  >= RESET_LAST);
        suspend_hit = idle_now && (idle_cnt_q >= SUSPEND_LAST);
        resume_hit  = k_now && !drive_k_q && (k_cnt_q >= RESUME_LAST);
        // Level-qualified only: a request held from before eligibility is
        // honoured once the idle time has elapsed, nothing is latched.
        wake_ok     = wakeup_req && remote_wakeup_en && (susp_cnt_q >= WAKE_IDLE);
        drive_done  = (drv_cnt_q >= DRIVE_LAST);

        // The resume sequence ends with SE0 (EOP) followed by J.
        se0_seen_d  = (state_q == ST_RESUMING) && (se0_seen_q || se0_now);
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: every combinational output gets a default at the top of the block
    // so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACTIVE: begin
                if (reset_hit)        state_d = ST_BUS_RESET;
                else if (suspend_hit) state_d = ST_SUSPENDED;
            end
            ST_BUS_RESET: begin
                if (!se0_now)         state_d = ST_ACTIVE;
            end
            ST_SUSPENDED: begin
                if (reset_hit)        state_d = ST_BUS_RESET;
                else if (resume_hit)  state_d = ST_RESUMING;
                else if (wake_ok)     state_d = ST_WAKEUP;
            end
            ST_WAKEUP: begin
                // Bus is ours while driving K; line activity is ignored.
                if (drive_done)       state_d = ST_RESUMING;
            end
            ST_RESUMING: begin
                if (reset_hit)                 state_d = ST_BUS_RESET;
                else if (j_now && se0_seen_q)  state_d = ST_ACTIVE;
            end
            default:                  state_d = ST_ACTIVE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State, counters and registered outputs
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_ACTIVE;
            se0_cnt_q     <= '0;
            idle_cnt_q    <= '0;
            k_cnt_q       <= '0;
            drv_cnt_q     <= '0;
            susp_cnt_q    <= '0;
            se0_seen_q    <= 1'b0;
            suspend_m_q   <= 1'b1;
            usb_reset_q   <= 1'b0;
            usb_suspend_q <= 1'b0;
            resume_done_q <= 1'b0;
            drive_k_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            se0_cnt_q     <= se0_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            k_cnt_q       <= k_cnt_d;
            drv_cnt_q     <= drv_cnt_d;
            susp_cnt_q    <= susp_cnt_d;
            se0_seen_q    <= se0_seen_d;
            // Outputs decode the next state so they change on the same edge
            // as the state register.
            suspend_m_q   <= (state_d != ST_SUSPENDED);
            usb_reset_q   <= (state_d == ST_BUS_RESET);
            usb_suspend_q <= (state_d == ST_SUSPENDED) || (state_d == ST_WAKEUP);
            resume_done_q <= (state_q == ST_RESUMING) && (state_d == ST_ACTIVE);
            drive_k_q     <= (state_d == ST_WAKEUP);
        end
    end

    assign suspend_m   = suspend_m_q;
    assign usb_reset   = usb_reset_q;
    assign usb_suspend = usb_suspend_q;
    assign resume_done = resume_done_q;
    assign drive_k     = drive_k_q;
    assign ctrl_state  = state_q;

endmodule

// File: tb/tb_usb_line_ctrl.sv
// -----------------------------------------------------------------------------
// tb_usb_line_ctrl
//
// Directed bench for usb_line_ctrl with shortened timing parameters.
// Inputs change on the falling edge; outputs are sampled on the following
// falling edge, i.e. after the rising edge that sampled the input vector.
// -----------------------------------------------------------------------------

module tb_usb_line_ctrl;
    import usb_line_pkg::*;

    localparam logic [2:0] ST_ACTIVE    = 3'd0;
    localparam logic [2:0] ST_BUS_RESET = 3'd1;
    localparam logic [2:0] ST_SUSPENDED = 3'd2;
    localparam logic [2:0] ST_RESUMING  = 3'd3;
    localparam logic [2:0] ST_WAKEUP    = 3'd4;

    logic             clk = 1'b0;
    logic             rst;
    utmi_line_state_t line_state;
    logic             rx_active, tx_active, remote_wakeup_en, wakeup_req;
    logic             suspend_m, usb_reset, usb_suspend, resume_done, drive_k;
    logic [2:0]       ctrl_state;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    usb_line_ctrl #(
        .RESET_DETECT_CYC  (16),
        .SUSPEND_CYC       (64),
        .RESUME_DETECT_CYC (4),
        .WAKEUP_IDLE_CYC   (80),
        .WAKEUP_DRIVE_CYC  (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .line_state       (line_state),
        .rx_active        (rx_active),
        .tx_active        (tx_active),
        .remote_wakeup_en (remote_wakeup_en),
        .wakeup_req       (wakeup_req),
        .suspend_m        (suspend_m),
        .usb_reset        (usb_reset),
        .usb_suspend      (usb_suspend),
        .resume_done      (resume_done),
        .drive_k          (drive_k),
        .ctrl_state       (ctrl_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input utmi_line_state_t ls);
        line_state = ls;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input utmi_line_state_t ls, input int n);
        for (int i = 0; i < n; i++) step(ls);
    endtask

    // One non-idle cycle, then exactly 64 idle samples; the 64th enters suspend.
    task automatic enter_suspend();
        rx_active = 1'b1;
        step(LS_J);
        rx_active = 1'b0;
        steps(LS_J, 63);
        check("pre_suspend_m", suspend_m, 1);
        step(LS_J);
        check("suspend_entry", ctrl_state, ST_SUSPENDED);
    endtask

    initial begin
        logic saw;
        int   hi;

        rst              = 1'b1;
        line_state       = LS_J;
        rx_active        = 1'b0;
        tx_active        = 1'b0;
        remote_wakeup_en = 1'b0;
        wakeup_req       = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // ---------------- reset values ----------------
        check("rst_state",       ctrl_state,  ST_ACTIVE);
        check("rst_suspend_m",   suspend_m,   1);
        check("rst_usb_reset",   usb_reset,   0);
        check("rst_usb_suspend", usb_suspend, 0);
        check("rst_resume_done", resume_done, 0);
        check("rst_drive_k",     drive_k,     0);
        rst = 1'b0;

        // ---------------- bus reset ----------------
        steps(LS_J, 5);
        saw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step(LS_SE0);
            saw |= usb_reset;
        end
        check("short_se0_ignored", saw, 0);
        step(LS_J);
        for (int i = 0; i < 40; i++) begin
            step(LS_SE0);
            check("bus_reset_level", usb_reset, (i >= 15) ? 1 : 0);
        end
        check("bus_reset_state", ctrl_state, ST_BUS_RESET);
        step(LS_J);
        check("bus_reset_release", usb_reset,  0);
        check("after_reset_state", ctrl_state, ST_ACTIVE);

        // ---------------- suspend ----------------
        steps(LS_J, 49);
        rx_active = 1'b1;
        step(LS_J);
        rx_active = 1'b0;
        steps(LS_J, 63);
        check("susp_63_idle", suspend_m, 1);
        step(LS_J);
        check("susp_64_idle",   suspend_m,   0);
        check("susp_usb_susp",  usb_suspend, 1);
        check("susp_state",     ctrl_state,  ST_SUSPENDED);

        // ---------------- host resume ----------------
        steps(LS_K, 3);
        step(LS_J);
        check("short_k_ignored", ctrl_state, ST_SUSPENDED);
        steps(LS_K, 3);
        check("resume_3k", suspend_m, 0);
        step(LS_K);
        check("resume_4k_susp_m", suspend_m,   1);
        check("resume_4k_state",  ctrl_state,  ST_RESUMING);
        check("resume_usb_susp",  usb_suspend, 0);
        steps(LS_K, 196);
        steps(LS_SE0, 8);
        check("resume_eop_state", ctrl_state,  ST_RESUMING);
        check("resume_eop_done",  resume_done, 0);
        step(LS_J);
        check("resume_done_pulse", resume_done, 1);
        check("resume_active",     ctrl_state,  ST_ACTIVE);
        step(LS_J);
        check("resume_done_once",  resume_done, 0);

        // ---------------- remote wakeup, enabled ----------------
        enter_suspend();
        remote_wakeup_en = 1'b1;
        saw = 1'b0;
        for (int s = 0; s < 80; s++) begin
            if (s == 10) wakeup_req = 1'b1;
            step(LS_J);
            saw |= drive_k;
        end
        check("wake_not_early",   ctrl_state, ST_SUSPENDED);
        check("wake_no_early_dk", saw, 0);
        step(LS_J);
        check("wake_state",     ctrl_state,  ST_WAKEUP);
        check("wake_drive_k",   drive_k,     1);
        check("wake_suspend_m", suspend_m,   1);
        check("wake_usb_susp",  usb_suspend, 1);
        wakeup_req = 1'b0;
        hi = 1;
        for (int i = 0; i < 100; i++) begin
            step(LS_J);
            if (drive_k) hi++;
            else break;
        end
        check("wake_drive_len", hi, 32);
        check("wake_to_resuming", ctrl_state, ST_RESUMING);
        steps(LS_J, 3);
        check("j_without_se0", ctrl_state, ST_RESUMING);
        steps(LS_SE0, 2);
        step(LS_J);
        check("wake_resume_done", resume_done, 1);
        check("wake_active",      ctrl_state,  ST_ACTIVE);

        // ---------------- remote wakeup, disabled ----------------
        enter_suspend();
        remote_wakeup_en = 1'b0;
        saw = 1'b0;
        for (int s = 0; s < 120; s++) begin
            if (s == 10) wakeup_req = 1'b1;
            step(LS_J);
            saw |= drive_k;
        end
        check("nowake_state", ctrl_state, ST_SUSPENDED);
        check("nowake_dk",    saw, 0);
        wakeup_req = 1'b0;
        steps(LS_K, 4);
        check("nowake_resume", ctrl_state, ST_RESUMING);
        steps(LS_SE0, 2);
        step(LS_J);
        check("nowake_active", ctrl_state, ST_ACTIVE);

        // ---------------- reset beats wakeup ----------------
        enter_suspend();
        remote_wakeup_en = 1'b1;
        saw = 1'b0;
        for (int s = 0; s < 65; s++) begin
            if (s == 10) wakeup_req = 1'b1;
            step(LS_J);
        end
        for (int s = 65; s < 80; s++) begin
            step(LS_SE0);
            saw |= drive_k;
        end
        check("prio_pre_state", ctrl_state, ST_SUSPENDED);
        step(LS_SE0);
        saw |= drive_k;
        check("prio_state",     ctrl_state, ST_BUS_RESET);
        check("prio_usb_reset", usb_reset,  1);
        check("prio_suspend_m", suspend_m,  1);
        check("prio_no_dk",     saw, 0);
        wakeup_req = 1'b0;
        step(LS_J);
        check("prio_active", ctrl_state, ST_ACTIVE);

        // ---------------- rst during wakeup ----------------
        enter_suspend();
        remote_wakeup_en = 1'b1;
        wakeup_req       = 1'b1;
        steps(LS_J, 81);
        check("midwake_state", ctrl_state, ST_WAKEUP);
        steps(LS_J, 5);
        rst = 1'b1;
        #1;
        check("midwake_rst_dk",     drive_k,     0);
        check("midwake_rst_susp_m", suspend_m,   1);
        check("midwake_rst_state",  ctrl_state,  ST_ACTIVE);
        check("midwake_rst_usbs",   usb_suspend, 0);
        wakeup_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(LS_J);
        check("post_rst_state", ctrl_state, ST_ACTIVE);
        check("post_rst_dk",    drive_k,    0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/usb_line_ctrl.md
# usb_line_ctrl

Full-speed bus line-condition controller on the UTMI receive side. It watches `line_state`, `rx_active` and `tx_active` and detects USB bus reset, suspend and host resume. It sequences device remote wakeup. It drives `suspend_m` back to the receive macrocell and reports bus events to the SIE/protocol layer.

## Interface
Parameters (all counts in `clk` cycles, `clk` = 48 MHz, 4× FS bit rate):
- `RESET_DETECT_CYC`, 480: consecutive SE0 cycles that declare bus reset (10 µs).
- `SUSPEND_CYC`, 144000: consecutive idle cycles that declare suspend (3 ms).
- `RESUME_DETECT_CYC`, 48: consecutive K cycles while suspended that declare host resume (1 µs).
- `WAKEUP_IDLE_CYC`, 240000: minimum idle cycles (5 ms), counted from the start of suspend, before remote wakeup is allowed.
- `WAKEUP_DRIVE_CYC`, 96000: length of the device-driven K (2 ms).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `line_state`  in  `utmi_line_state_t`  registered line state from the UTM receiver.
- `rx_active`  in  1  receive FSM active.
- `tx_active`  in  1  transmitter active.
- `remote_wakeup_en`  in  1  host has enabled remote wakeup (level).
- `wakeup_req`  in  1  wakeup request, a level held by the requester.
- `suspend_m`  out  1  UTMI SuspendM; 0 = macrocell suspended.
- `usb_reset`  out  1  high while in BUS_RESET.
- `usb_suspend`  out  1  high while in SUSPENDED or WAKEUP.
- `resume_done`  out  1  one-cycle pulse on the RESUMING→ACTIVE transition.
- `drive_k`  out  1  request to the transmitter to force K on the bus.
- `ctrl_state`  out  3  current FSM state encoding, for debug.

## Operation
- Counters (width `$clog2` of the largest parameter + 1; all saturate, none wrap):
  - `se0_cnt` increments while `line_state==SE0` and clears otherwise.
  - `idle_cnt` increments while `line_state==J && !rx_active && !tx_active` and clears otherwise.
  - `k_cnt` increments while `line_state==K && !drive_k` and clears otherwise.
  - `drv_cnt` is the wakeup drive timer; it runs only in WAKEUP.
  - `susp_cnt` counts cycles spent in SUSPENDED and clears on entry.
- FSM states: ACTIVE, BUS_RESET, SUSPENDED, RESUMING, WAKEUP.
- ACTIVE:
  - goes to BUS_RESET on the `RESET_DETECT_CYC`-th consecutive SE0;
  - else goes to SUSPENDED on the `SUSPEND_CYC`-th consecutive idle cycle.
- BUS_RESET: stays while SE0; goes to ACTIVE on the first non-SE0 cycle. `idle_cnt` restarts there.
- SUSPENDED:
  - goes to BUS_RESET on the `RESET_DETECT_CYC`-th SE0. This has top priority.
  - else goes to RESUMING on the `RESUME_DETECT_CYC`-th consecutive K.
  - else goes to WAKEUP when `wakeup_req && remote_wakeup_en && susp_cnt >= WAKEUP_IDLE_CYC`.
  - A `wakeup_req` arriving before eligibility is not latched. It is honoured once eligibility is reached if it is still held.
- WAKEUP:
  - `drive_k=1` for exactly `WAKEUP_DRIVE_CYC` cycles, then goes to RESUMING.
  - Line activity is ignored in this state.
- RESUMING:
  - records that SE0 has been seen.
  - goes to ACTIVE on the first J after SE0 has been seen.
  - goes to BUS_RESET on the `RESET_DETECT_CYC`-th SE0.
  - J without a prior SE0 keeps the block in RESUMING.
- Short events:
  - K runs shorter than `RESUME_DETECT_CYC` are ignored.
  - SE0 runs shorter than `RESET_DETECT_CYC` (for example an EOP) are ignored.
  - Any non-idle cycle restarts the suspend timer.
- Simultaneous conditions: reset detection beats suspend, resume and wakeup.

## Timing
- Reset values:
  - `ctrl_state` = ACTIVE;
  - `suspend_m` = 1;
  - `usb_reset` = 0, `usb_suspend` = 0, `resume_done` = 0, `drive_k` = 0;
  - all counters = 0.
- All outputs are registered and decoded from the state register. Each output changes on the clock edge that samples the triggering condition (latency 1 from the input sample).
- `suspend_m`:
  - falls on the edge entering SUSPENDED;
  - rises on the edge leaving SUSPENDED to any state, including entry to WAKEUP, so the macrocell is awake before K is driven.
- `drive_k`:
  - rises on the edge entering WAKEUP;
  - falls on the edge entering RESUMING;
  - high for exactly `WAKEUP_DRIVE_CYC` cycles.
- `resume_done`: high for exactly one cycle, the first cycle in ACTIVE after RESUMING.
- Asserting `rst` mid-operation returns immediately to reset values, including dropping `drive_k`.

## Test plan
The bench overrides parameters: `RESET_DETECT_CYC`=16, `SUSPEND_CYC`=64, `RESUME_DETECT_CYC`=4, `WAKEUP_IDLE_CYC`=80, `WAKEUP_DRIVE_CYC`=32.
- **Bus reset:** J idle, then SE0 for 15 cycles, then J → no `usb_reset`. Then SE0 for 40 cycles, then J → `usb_reset` high from the 16th SE0 sample until the first J, after which state is ACTIVE.
- **Suspend:** J idle with `rx_active` pulsing at cycle 50, then idle → `suspend_m` falls 64 cycles after the pulse ends; `usb_suspend`=1.
- **Host resume:** suspended, then K for 3 cycles, then J → stays SUSPENDED. Then K for 200 cycles, SE0 for 8, J → `suspend_m` rises on the 4th K; `resume_done` pulses once on the first J; state is ACTIVE.
- **Remote wakeup:**
  - `wakeup_req`=1 at suspend cycle 10 with `remote_wakeup_en`=1 → WAKEUP entered at `susp_cnt`=80; `drive_k` high for 32 cycles; RESUMING follows.
  - Same sequence with `remote_wakeup_en`=0 → no wakeup.
- **Reset priority:** suspended with `wakeup_req` eligible on the same cycle as the 16th SE0 → BUS_RESET; `drive_k` never asserted.
- **Reset mid-wakeup:** `rst` pulsed during WAKEUP → `drive_k`=0 and `suspend_m`=1 immediately; state ACTIVE.
